// File: rtl/memlcd_line_serializer.sv
// Sharp memory-LCD 3-wire serializer: one multi-line data-update command per start,
// streaming frame-buffer words LSB-first with a one-word prefetch ahead of the shifter.
module memlcd_line_serializer #(
  parameter int LINE_PIXELS = 400,
  parameter int LINES       = 240,
  parameter int WORD_W      = 16,
  parameter int SCLK_DIV    = 4,
  parameter int SCS_SETUP   = 16,
  parameter int SCS_HOLD    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        start_line,
  input  logic [7:0]        end_line,
  input  logic              vcom,
  output logic              busy,
  output logic              done,
  output logic              fb_rd,
  output logic [7:0]        fb_line,
  output logic [7:0]        fb_word,
  input  logic [WORD_W-1:0] fb_data,
  output logic              lcd_sclk,
  output logic              lcd_si,
  output logic              lcd_scs
);

  localparam int BIT_W = $clog2(LINE_PIXELS + 1);
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DIV_W = $clog2(2 * SCLK_DIV);
  localparam int CMAX  = (SCS_SETUP > SCS_HOLD) ? SCS_SETUP : SCS_HOLD;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int SH_W  = (WORD_W > 8) ? WORD_W : 8;
  localparam int WPL   = LINE_PIXELS / WORD_W;

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_MODE, S_ADDR, S_DATA, S_DUMMY, S_TRAILER, S_HOLD, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]  r_bit, w_bit_nxt;
  logic [WB_W-1:0]   r_wbit, w_wbit_nxt;
  logic [SH_W-1:0]   r_sh, w_sh_nxt;
  logic [WORD_W-1:0] r_fbbuf;
  logic              r_rd_d;
  logic [7:0]        r_line, w_line_nxt;
  logic [7:0]        r_end, w_end_nxt;
  logic              r_vcom, w_vcom_nxt;
  logic              r_fb_rd, w_fb_rd_nxt;
  logic [7:0]        r_fb_line, w_fb_line_nxt;
  logic [7:0]        r_fb_word, w_fb_word_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_scs, w_scs_nxt;

  logic              w_bit_end;
  logic              w_in_bits;
  logic              w_nxt_in_bits;
  logic              w_range_bad;
  logic [7:0]        w_line_inc;
  logic [7:0]        w_line_inc2;

  assign w_bit_end     = (r_div == DIV_W'(2 * SCLK_DIV - 1));
  assign w_in_bits     = r_state inside {S_MODE, S_ADDR, S_DATA, S_DUMMY, S_TRAILER};
  assign w_nxt_in_bits = w_state_nxt inside {S_MODE, S_ADDR, S_DATA, S_DUMMY, S_TRAILER};
  assign w_range_bad   = (start_line > end_line) || (int'(end_line) >= LINES);
  assign w_line_inc    = r_line + 8'd1;
  assign w_line_inc2   = r_line + 8'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_wbit    <= '0;
      r_sh      <= '0;
      r_fbbuf   <= '0;
      r_rd_d    <= 1'b0;
      r_line    <= '0;
      r_end     <= '0;
      r_vcom    <= 1'b0;
      r_fb_rd   <= 1'b0;
      r_fb_line <= '0;
      r_fb_word <= '0;
      r_sclk    <= 1'b0;
      r_scs     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_wbit    <= w_wbit_nxt;
      r_sh      <= w_sh_nxt;
      r_rd_d    <= r_fb_rd;
      if (r_rd_d) r_fbbuf <= fb_data;
      r_line    <= w_line_nxt;
      r_end     <= w_end_nxt;
      r_vcom    <= w_vcom_nxt;
      r_fb_rd   <= w_fb_rd_nxt;
      r_fb_line <= w_fb_line_nxt;
      r_fb_word <= w_fb_word_nxt;
      r_sclk    <= w_sclk_nxt;
      r_scs     <= w_scs_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_cnt_nxt     = r_cnt;
    w_bit_nxt     = r_bit;
    w_wbit_nxt    = r_wbit;
    w_sh_nxt      = r_sh;
    w_line_nxt    = r_line;
    w_end_nxt     = r_end;
    w_vcom_nxt    = r_vcom;
    w_fb_rd_nxt   = 1'b0;
    w_fb_line_nxt = r_fb_line;
    w_fb_word_nxt = r_fb_word;
    w_scs_nxt     = r_scs;

    // Shared bit-cell engine: the shifter advances once per completed bit.
    if (w_in_bits) begin
      w_div_nxt = w_bit_end ? '0 : r_div + 1'b1;
      if (w_bit_end) begin
        w_sh_nxt  = r_sh >> 1;
        w_bit_nxt = r_bit + 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_range_bad) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SETUP;
            w_line_nxt  = start_line;
            w_end_nxt   = end_line;
            w_vcom_nxt  = vcom;
            w_cnt_nxt   = '0;
            w_scs_nxt   = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == CNT_W'(SCS_SETUP - 1)) begin
          w_state_nxt = S_MODE;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_sh_nxt    = SH_W'({r_vcom, 1'b1});
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_MODE: begin
        if (w_bit_end && r_bit == BIT_W'(7)) begin
          w_state_nxt   = S_ADDR;
          w_bit_nxt     = '0;
          w_sh_nxt      = SH_W'(w_line_inc);
          w_fb_rd_nxt   = 1'b1;
          w_fb_line_nxt = r_line;
          w_fb_word_nxt = '0;
        end
      end
      S_ADDR: begin
        if (w_bit_end && r_bit == BIT_W'(7)) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_wbit_nxt  = '0;
          w_sh_nxt    = SH_W'(r_fbbuf);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_wbit_nxt = r_wbit + 1'b1;
          // Fetch the next word as the last bit of this one starts.
          if (r_wbit == WB_W'(WORD_W - 2) && r_fb_word != 8'(WPL - 1)) begin
            w_fb_rd_nxt   = 1'b1;
            w_fb_word_nxt = r_fb_word + 8'd1;
          end
          if (r_wbit == WB_W'(WORD_W - 1)) begin
            w_wbit_nxt = '0;
            w_sh_nxt   = SH_W'(r_fbbuf);
          end
          if (r_bit == BIT_W'(LINE_PIXELS - 1)) begin
            w_state_nxt = S_DUMMY;
            w_bit_nxt   = '0;
            w_sh_nxt    = '0;
          end
        end
      end
      S_DUMMY: begin
        if (w_bit_end && r_bit == BIT_W'(7)) begin
          w_bit_nxt = '0;
          if (r_line == r_end) begin
            w_state_nxt = S_TRAILER;
          end else begin
            w_state_nxt   = S_ADDR;
            w_line_nxt    = w_line_inc;
            w_sh_nxt      = SH_W'(w_line_inc2);
            w_fb_rd_nxt   = 1'b1;
            w_fb_line_nxt = w_line_inc;
            w_fb_word_nxt = '0;
          end
        end
      end
      S_TRAILER: begin
        if (w_bit_end && r_bit == BIT_W'(7)) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
          w_sh_nxt    = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == CNT_W'(SCS_HOLD - 1)) begin
          w_state_nxt = S_DONE;
          w_scs_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_scs_nxt   = 1'b0;
      end
    endcase

    w_sclk_nxt = w_nxt_in_bits && (w_div_nxt >= DIV_W'(SCLK_DIV));
  end

  // busy spans exactly the chip-select window; rejected starts never raise it.
  assign busy     = r_scs;
  assign done     = (r_state == S_DONE);
  assign fb_rd    = r_fb_rd;
  assign fb_line  = r_fb_line;
  assign fb_word  = r_fb_word;
  assign lcd_sclk = r_sclk;
  assign lcd_si   = r_sh[0];
  assign lcd_scs  = r_scs;

endmodule

// File: doc/memlcd_line_serializer.md
Name: memlcd_line_serializer

Overview:
- Drives the Sharp memory-LCD 3-wire serial bus (SCLK/SI/SCS) from a line-organised frame buffer read port.
- Emits one multi-line "data update" command per start request, covering lines start_line..end_line inclusive.
- Sits directly upstream of the panel pins and downstream of the frame buffer and update controller in the memlcd top.
- Purely sequential: bit timer, bit/word/line counters, one-word prefetch and a protocol state machine.

Parameters:
- LINE_PIXELS, 400, pixels per line; must be a multiple of WORD_W.
- LINES, 240, panel line count; must be ≤ 255.
- WORD_W, 16, frame-buffer word width in bits.
- SCLK_DIV, 4, clk cycles per SCLK half-period; must be ≥ 2.
- SCS_SETUP, 16, clk cycles from SCS rise to the first SCLK activity.
- SCS_HOLD, 16, clk cycles from the last SCLK fall to SCS fall.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_line  in  8  first line, 0-based; latched on an accepted start.
- end_line  in  8  last line, 0-based; latched on an accepted start.
- vcom  in  1  VCOM polarity bit; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- fb_rd  out  1  frame-buffer read strobe.
- fb_line  out  8  line index for the read (0-based).
- fb_word  out  8  word index within the line.
- fb_data  in  WORD_W  read data, valid exactly 1 clk after fb_rd.
- lcd_sclk  out  1  serial clock; idles low.
- lcd_si  out  1  serial data.
- lcd_scs  out  1  chip select, active high.

Behaviour:
- Reset (async, rst_n=0): lcd_scs=0, lcd_sclk=0, lcd_si=0, busy=0, done=0, fb_rd=0, fb_line=0, fb_word=0, FSM=IDLE. Takes effect immediately, including mid-frame.
- Bit cell:
  - lcd_si is updated while lcd_sclk is low.
  - lcd_sclk is low for SCLK_DIV clks, then high for SCLK_DIV clks.
  - The panel samples on the rising edge.
  - One bit = 2*SCLK_DIV clks.
- States and transitions:
  - IDLE: accept start.
    - If start_line > end_line or end_line ≥ LINES, pulse done next cycle, leave lcd_scs low, and never assert busy.
    - Otherwise latch the inputs, set busy=1 and lcd_scs=1, then go to SETUP.
  - SETUP: wait SCS_SETUP clks → MODE.
  - MODE: 8 bits, in order M0=1, M1=vcom, M2=0, then five 0s → ADDR.
  - ADDR: 8 bits of (line+1), LSB first → DATA.
  - DATA: LINE_PIXELS bits. Word bit 0 is sent first and is the leftmost pixel. Word 0 is sent first → DUMMY.
  - DUMMY: 8 zero bits.
    - If line == end_line → TRAILER.
    - Otherwise line++ → ADDR.
  - TRAILER: 8 zero bits. Together with the last DUMMY this forms the 16-bit frame trailer → HOLD.
  - HOLD: SCS_HOLD clks with lcd_sclk low, then lcd_scs=0 → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Frame-buffer fetch:
  - Word 0 of a line is fetched during the ADDR state (fb_rd one clk).
  - Word k+1 is fetched at the start of the last bit of word k.
  - fb_data is captured into a shift register 1 clk after fb_rd.
  - fb_rd is never asserted outside DATA/ADDR, and never twice for the same (line, word).
  - Exactly LINE_PIXELS/WORD_W reads are issued per line.
- Counters:
  - Bit counter width is ceil(log2(LINE_PIXELS+1)).
  - Line counter is 8 bits and wraps nothing, since the range is validated at start.
- Start handling: a start pulse while busy is ignored; the latched parameters are unchanged.
- Total frame length in clks: SCS_SETUP + (16 + N*(16+LINE_PIXELS))*2*SCLK_DIV + SCS_HOLD, with N = end_line − start_line + 1.
- vcom changes mid-frame have no effect until the next start.

Test Plan:
- Single line: LINE_PIXELS=32, WORD_W=16, SCLK_DIV=2, start_line=end_line=0, vcom=0, fb words 0xA5A5 then 0x0001 → bus decodes as mode 0x80 (M0 first), address 0x01 LSB-first, the 32 data bits, 16 zeros; SCS high for 16+16+(16+48)*4 clks; exactly 2 fb_rd pulses.
- Multi-line: start_line=3, end_line=5 → addresses 4, 5, 6 in order; 8 dummy bits between lines; fb_line sequences 3, 4, 5; done pulses exactly once.
- vcom=1 → second mode bit =1 and all other mode bits unchanged; toggling vcom mid-frame does not alter the frame.
- Start while busy: pulse start with a different range mid-frame → ignored; the frame completes with the original range; no extra done pulse.
- Invalid range: start_line=7, end_line=2 → done next cycle; lcd_scs, lcd_sclk and fb_rd stay 0; busy never 1.
- Reset mid-DATA: drop rst_n → all outputs 0 in the same cycle; after release, a new start produces a full, correct frame.
